rgb_btn_sequencer: RTL

Clocked controller for the board's two active-low push buttons and active-low RGB LED. It synchronizes and debounces both buttons and turns clean presses into one-cycle events. Button A steps a colour state machine and button B steps a brightness level. The LED channels are driven through a free-running PWM so each colour shows at the selected brightness. It sits directly between the button pins and the LED pins and replaces purely combinational button-to-LED wiring.

---
 rtl/rgb_btn_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rgb_btn_sequencer.sv
// Button-driven RGB LED controller: debounces two active-low buttons, steps a colour
// state machine (button A) and a brightness level (button B), and PWMs the active-low LED.
module rgb_btn_sequencer #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int PWM_BITS        = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn_a,
   input  logic i_btn_b,
   output logic o_led_r,
   output logic o_led_g,
   output logic o_led_b
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int DW = PWM_BITS + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      C_OFF,
      C_RED,
      C_GREEN,
      C_BLUE,
      C_WHITE
   } colour_t;

   logic [1:0]    pins;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    deb;
   logic [1:0]    press_evt;
   logic [CW-1:0] db_cnt [2];

   colour_t             colour;
   logic [1:0]          level;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [DW-1:0]       duty;
   logic                pwm_on;
   logic                en_r;
   logic                en_g;
   logic                en_b;

   assign pins = {i_btn_b, i_btn_a};

   // Index 0 is button A, index 1 is button B; deb holds the active-high pressed level.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync1     <= '1;
         sync2     <= '1;
         deb       <= '0;
         press_evt <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync1     <= pins;
         sync2     <= sync1;
         press_evt <= '0;
         for (int i = 0; i < 2; i++) begin
            if (~sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               deb[i]       <= ~sync2[i];
               db_cnt[i]    <= '0;
               press_evt[i] <= ~sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      duty   = DW'(1) << (PWM_BITS - 3 + int'(level));
      pwm_on = (level == 2'd3) || ({1'b0, pwm_cnt} < duty);
      en_r   = 1'b0;
      en_g   = 1'b0;
      en_b   = 1'b0;
      case (colour)
         C_RED:   en_r = 1'b1;
         C_GREEN: en_g = 1'b1;
         C_BLUE:  en_b = 1'b1;
         C_WHITE: begin
            en_r = 1'b1;
            en_g = 1'b1;
            en_b = 1'b1;
         end
         default: ;
      endcase
   end

   // LED registers sample the current counter, so light trails the counter by one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         colour  <= C_OFF;
         level   <= 2'd3;
         pwm_cnt <= '0;
         o_led_r <= 1'b1;
         o_led_g <= 1'b1;
         o_led_b <= 1'b1;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (press_evt[0]) begin
            case (colour)
               C_OFF:   colour <= C_RED;
               C_RED:   colour <= C_GREEN;
               C_GREEN: colour <= C_BLUE;
               C_BLUE:  colour <= C_WHITE;
               default: colour <= C_OFF;
            endcase
         end
         if (press_evt[1]) begin
            level <= level + 2'd1;
         end
         o_led_r <= ~(en_r & pwm_on);
         o_led_g <= ~(en_g & pwm_on);
         o_led_b <= ~(en_b & pwm_on);
      end
   end

endmodule
